// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART receive-side blocks.
//   rx_state_t    one-hot sequencer states for uart_rx_ctrl
//   parity_t      parity mode encoding, common to uart_rx and its controller
//   timeout_ticks frame timeout length in baud ticks
package uart_pkg;

  typedef enum logic [3:0] {
    ST_OFF     = 4'b0001,
    ST_HUNT    = 4'b0010,
    ST_RECV    = 4'b0100,
    ST_RECOVER = 4'b1000
  } rx_state_t;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  function automatic int timeout_ticks(input int bits, input int osr);
    return bits * osr;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: small synchronous FIFO with a first-word-fall-through head.
//   push/din   write; ignored when full unless a pop happens in the same cycle
//   pop        read; ignored when empty
//   dout       current head (zero while empty), valid whenever empty==0
//   full/empty occupancy flags, both derived from the registered count
module uart_sync_fifo #(
  parameter int data_wd    = 8,
  parameter int fifo_depth = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [data_wd-1:0] din,
  input  logic               pop,
  output logic [data_wd-1:0] dout,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(fifo_depth);

  logic [data_wd-1:0] mem [fifo_depth];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        cnt;
  logic               do_push, do_pop;

  // a pop frees the slot the same cycle, so a push on full is still taken
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == (AW+1)'(fifo_depth));
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencer between the serial line, uart_rx and the host.
//   clk, rst            system clock, async active-high reset
//   enable              arms the receive path; low forces OFF
//   clr_status          pulse: clears overrun and both error counters
//   tick                baud tick shared with uart_rx
//   rx                  raw serial line (asynchronous)
//   rx_start, rx_clr    pulses to uart_rx: begin a frame / abort a frame
//   rx_done, rx_busy, parity_error_flag, framing_error_flag, rx_dout  from uart_rx
//   rd_data, rd_valid, rd_ready   host side of the receive FIFO
//   overrun             sticky: a frame was dropped on a full FIFO
//   timeout_err         pulse: a frame was aborted by the timeout
//   frame_err_cnt, parity_err_cnt  saturating error counters
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int data_wd           = 8,
  parameter int oversampling_rate = 16,
  parameter int fifo_depth        = 4,
  parameter int cnt_wd            = 8,
  parameter int timeout_bits      = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clr_status,
  input  logic               tick,
  input  logic               rx,
  output logic               rx_start,
  output logic               rx_clr,
  input  logic               rx_done,
  input  logic               rx_busy,
  input  logic               parity_error_flag,
  input  logic               framing_error_flag,
  input  logic [data_wd-1:0] rx_dout,
  output logic [data_wd-1:0] rd_data,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic               overrun,
  output logic               timeout_err,
  output logic [cnt_wd-1:0]  frame_err_cnt,
  output logic [cnt_wd-1:0]  parity_err_cnt
);
  localparam int TO_TICKS = timeout_ticks(timeout_bits, oversampling_rate);
  localparam int TW       = $clog2(TO_TICKS);
  localparam int IW       = $clog2(oversampling_rate + 1);
  localparam logic [TW-1:0]     TO_LAST  = TW'(TO_TICKS - 1);
  localparam logic [IW-1:0]     IDLE_MAX = IW'(oversampling_rate);
  localparam logic [cnt_wd-1:0] CNT_MAX  = '1;

  rx_state_t     state, state_n;
  logic          rx_m, rx_s, rx_s_prev, fall;
  logic          done_d, fe_d, pe_d, done_rise, fe_rise, pe_rise;
  logic [TW-1:0] timer;
  logic [IW-1:0] idle_cnt;
  logic          start_n, clr_n, to_n, push, fe_inc, pe_inc;
  logic          pop, fifo_full, fifo_empty;

  // line idles high, so the synchronizer resets to 1 to avoid a false start edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {rx_m, rx_s, rx_s_prev} <= '1;
      {done_d, fe_d, pe_d}    <= '0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      rx_s_prev <= rx_s;
      done_d    <= rx_done;
      fe_d      <= framing_error_flag;
      pe_d      <= parity_error_flag;
    end
  end

  assign fall      = rx_s_prev & ~rx_s;
  // uart_rx holds its status lines for several cycles; act once per event
  assign done_rise = rx_done & ~done_d;
  assign fe_rise   = framing_error_flag & ~fe_d;
  assign pe_rise   = parity_error_flag & ~pe_d;

  always_comb begin
    state_n = state;
    start_n = 1'b0;
    clr_n   = 1'b0;
    to_n    = 1'b0;
    push    = 1'b0;
    fe_inc  = 1'b0;
    pe_inc  = 1'b0;
    if (!enable) begin
      state_n = ST_OFF;
      clr_n   = (state == ST_RECV);
    end else begin
      case (state)
        ST_OFF:  state_n = ST_HUNT;
        ST_HUNT: if (fall && !rx_busy) begin
          start_n = 1'b1;
          state_n = ST_RECV;
        end
        ST_RECV: begin
          // errors take precedence so a flagged frame is never stored
          if (fe_rise || pe_rise) begin
            fe_inc  = fe_rise;
            pe_inc  = pe_rise;
            state_n = ST_RECOVER;
          end else if (done_rise) begin
            push    = 1'b1;
            state_n = ST_HUNT;
          end else if (tick && timer == TO_LAST) begin
            clr_n   = 1'b1;
            to_n    = 1'b1;
            state_n = ST_RECOVER;
          end
        end
        ST_RECOVER: if (idle_cnt == IDLE_MAX && !rx_busy) state_n = ST_HUNT;
        default: state_n = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_OFF;
      rx_start    <= 1'b0;
      rx_clr      <= 1'b0;
      timeout_err <= 1'b0;
      timer       <= '0;
      idle_cnt    <= '0;
    end else begin
      state       <= state_n;
      rx_start    <= start_n;
      rx_clr      <= clr_n;
      timeout_err <= to_n;
      if (start_n)                     timer <= '0;
      else if (state == ST_RECV && tick) timer <= timer + 1'b1;
      // idle run starts from zero on RECOVER entry; any low sample restarts it
      if (state != ST_RECOVER || !rx_s)        idle_cnt <= '0;
      else if (tick && idle_cnt != IDLE_MAX)   idle_cnt <= idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_cnt  <= '0;
      parity_err_cnt <= '0;
      overrun        <= 1'b0;
    end else if (clr_status) begin
      frame_err_cnt  <= '0;
      parity_err_cnt <= '0;
      overrun        <= 1'b0;
    end else begin
      if (fe_inc && frame_err_cnt != CNT_MAX)  frame_err_cnt  <= frame_err_cnt + 1'b1;
      if (pe_inc && parity_err_cnt != CNT_MAX) parity_err_cnt <= parity_err_cnt + 1'b1;
      if (push && fifo_full && !pop)           overrun        <= 1'b1;
    end
  end

  assign pop      = rd_ready & ~fifo_empty;
  assign rd_valid = ~fifo_empty;

  uart_sync_fifo #(.data_wd(data_wd), .fifo_depth(fifo_depth)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (rx_dout),
    .pop   (pop),
    .dout  (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl. A behavioural stand-in for uart_rx drives the line
// and the status lines; expected FIFO words go into exp_q when a frame is
// issued and a negedge monitor pops and compares on every host read.
module tb_uart_rx_ctrl;
  localparam int OSR = 16;
  localparam int TO_CYC = 12 * OSR;  // tick is held high, so one tick per cycle

  logic       clk = 1'b0;
  logic       rst, enable, clr_status, tick, rx;
  logic       rx_busy, rx_done, pe_flag, fe_flag, rd_ready;
  logic [7:0] rx_dout, rd_data, fe_cnt, pe_cnt;
  logic       rx_start, rx_clr, rd_valid, overrun, timeout_err;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .data_wd(8), .oversampling_rate(OSR), .fifo_depth(4), .cnt_wd(8), .timeout_bits(12)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_status(clr_status), .tick(tick), .rx(rx),
    .rx_start(rx_start), .rx_clr(rx_clr), .rx_done(rx_done), .rx_busy(rx_busy),
    .parity_error_flag(pe_flag), .framing_error_flag(fe_flag), .rx_dout(rx_dout),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .overrun(overrun),
    .timeout_err(timeout_err), .frame_err_cnt(fe_cnt), .parity_err_cnt(pe_cnt)
  );

  int         n_cmp = 0, n_bad = 0;
  int         n_start = 0, n_clr = 0, n_to = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pulse counters, start/abort exclusivity, scoreboard on pops
  initial forever begin
    @(negedge clk);
    if (rx_start)    n_start++;
    if (rx_clr)      n_clr++;
    if (timeout_err) n_to++;
    if (rx_start || rx_clr) chk("start_clr_exclusive", 32'(rx_start & rx_clr), 32'd0);
    if (rd_valid && rd_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected_qsize", 32'(exp_q.size()), 32'd1);
      else                   chk("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (rx_start) begin ok = 1'b1; break; end
    end
  endtask

  // mode 0: good frame, 1: parity error, 2: framing error (odd parity, 8 data bits)
  task automatic frame(input logic [7:0] d, input int mode, input bit push_exp);
    bit   ok;
    logic par;
    rx = 1'b0;
    wait_start(ok);
    chk("frame_rx_start", 32'(ok), 32'd1);
    if (ok && push_exp) exp_q.push_back(d);
    rx_busy = 1'b1;
    cyc(OSR - 3);
    for (int b = 0; b < 8; b++) begin rx = d[b]; cyc(OSR); end
    par = ~^d;
    if (mode == 1) par = ~par;
    rx = par; cyc(OSR);
    rx = (mode == 2) ? 1'b0 : 1'b1; cyc(OSR);
    rx_dout = d;
    rx_done = (mode == 0);
    pe_flag = (mode == 1);
    fe_flag = (mode == 2);
    cyc(3);
    {rx_done, pe_flag, fe_flag, rx_busy} = '0;
    rx = 1'b1;
    cyc(4);
  endtask

  // short error event: start, then flags straight away, then idle long enough to re-arm
  task automatic quick_err(input bit pe, input bit fe, input bit clr);
    bit ok;
    rx = 1'b0;
    wait_start(ok);
    chk("quick_rx_start", 32'(ok), 32'd1);
    rx_busy = 1'b1; rx = 1'b1; cyc(2);
    pe_flag = pe; fe_flag = fe; clr_status = clr;
    cyc(1);
    clr_status = 1'b0;
    cyc(2);
    {pe_flag, fe_flag, rx_busy} = '0;
    cyc(OSR + 4);
  endtask

  task automatic drain();
    int t = 0;
    rd_ready = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin cyc(1); t++; end
    chk("drain_qsize", 32'(exp_q.size()), 32'd0);
    cyc(2);
    chk("drain_rd_valid", 32'(rd_valid), 32'd0);
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1; cyc(1); clr_status = 1'b0; cyc(1);
  endtask

  initial begin
    bit ok;
    int s0, c0, t0, lat;
    rst = 1'b1; enable = 1'b0; clr_status = 1'b0; tick = 1'b1; rx = 1'b1;
    {rx_busy, rx_done, pe_flag, fe_flag, rd_ready} = '0;
    rx_dout = '0;
    #12;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_outputs", 32'({rx_start, rx_clr, overrun, timeout_err}), 32'd0);
    chk("rst_counters", 32'({fe_cnt, pe_cnt}), 32'd0);
    cyc(1); rst = 1'b0;
    enable = 1'b1; cyc(3);

    // single good frame
    s0 = n_start;
    frame(8'hA5, 0, 1);
    chk("a5_one_start", 32'(n_start - s0), 32'd1);
    chk("a5_rd_valid", 32'(rd_valid), 32'd1);
    drain();

    // five frames into a depth-4 FIFO with no reads
    rd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) frame(8'(i), 0, i <= 4);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_head", 32'(rd_data), 32'h01);
    drain();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    pulse_clr();
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // parity error: counted, not stored, re-arm needs a full high bit time
    frame(8'h96, 1, 0);
    chk("par_cnt", 32'(pe_cnt), 32'd1);
    chk("par_fe_cnt", 32'(fe_cnt), 32'd0);
    chk("par_no_push", 32'(rd_valid), 32'd0);
    s0 = n_start;
    rx = 1'b0; cyc(8); rx = 1'b1; cyc(10); rx = 1'b0; cyc(8);
    chk("par_no_rearm", 32'(n_start - s0), 32'd0);
    rx = 1'b1; cyc(24);
    frame(8'h5A, 0, 1);
    drain();

    // framing error
    frame(8'h33, 2, 0);
    chk("frm_cnt", 32'(fe_cnt), 32'd1);
    chk("frm_pe_cnt", 32'(pe_cnt), 32'd1);
    rx = 1'b1; cyc(24);

    // break: line low ~14 bit times, uart_rx never reports; timeout aborts
    s0 = n_start; c0 = n_clr; t0 = n_to;
    rx = 1'b0;
    wait_start(ok);
    chk("brk_start", 32'(ok), 32'd1);
    rx_busy = 1'b1;
    lat = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      if (rx_clr) begin lat = i + 1; break; end
    end
    chk("brk_timeout_latency", 32'(lat), 32'(TO_CYC));
    rx_busy = 1'b0;
    cyc(30);
    chk("brk_timeout_pulse", 32'(n_to - t0), 32'd1);
    chk("brk_rx_clr_pulse", 32'(n_clr - c0), 32'd1);
    rx = 1'b1; cyc(8); rx = 1'b0; cyc(16);
    chk("brk_no_rearm", 32'(n_start - s0), 32'd1);
    rx = 1'b1; cyc(24);
    frame(8'hC3, 0, 1);
    drain();

    // enable dropped mid-frame
    c0 = n_clr;
    rx = 1'b0;
    wait_start(ok);
    rx_busy = 1'b1;
    cyc(OSR - 3); rx = 1'b1; cyc(40);
    enable = 1'b0; cyc(3);
    rx_busy = 1'b0;
    chk("dis_rx_clr", 32'(n_clr - c0), 32'd1);
    chk("dis_no_push", 32'(rd_valid), 32'd0);
    s0 = n_start;
    rx = 1'b0; cyc(20); rx = 1'b1; cyc(20);
    chk("dis_off_no_start", 32'(n_start - s0), 32'd0);
    enable = 1'b1; cyc(3);
    frame(8'h3C, 0, 1);
    drain();

    // async reset in the middle of a frame
    rd_ready = 1'b0;
    frame(8'h77, 0, 0);
    chk("pre_rst_head", 32'(rd_data), 32'h77);
    rx = 1'b0;
    wait_start(ok);
    rx_busy = 1'b1;
    cyc(30);
    #3 rst = 1'b1;
    #1;
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    chk("arst_counters", 32'({fe_cnt, pe_cnt}), 32'd0);
    chk("arst_pulses", 32'({rx_start, rx_clr, timeout_err, overrun}), 32'd0);
    rx = 1'b1; rx_busy = 1'b0;
    cyc(2); rst = 1'b0; cyc(3);

    // saturation with both flags together, then clear racing an increment
    for (int i = 0; i < 257; i++) quick_err(1'b1, 1'b1, 1'b0);
    chk("sat_pe", 32'(pe_cnt), 32'd255);
    chk("sat_fe", 32'(fe_cnt), 32'd255);
    quick_err(1'b1, 1'b1, 1'b1);
    chk("clr_wins_pe", 32'(pe_cnt), 32'd0);
    chk("clr_wins_fe", 32'(fe_cnt), 32'd0);
    quick_err(1'b1, 1'b0, 1'b0);
    chk("post_clr_pe", 32'(pe_cnt), 32'd1);
    chk("post_clr_fe", 32'(fe_cnt), 32'd0);
    chk("final_qsize", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
